// File: rtl/regfile.sv
// regfile: NREG x DATA_W architectural register file with two combinational
// read ports, same-cycle write-through forwarding, a hardwired-zero x0 and a
// 32-bit count of committed writes.
module regfile #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32
) (
  input  logic              dclk,
  input  logic              rst,
  input  logic              wreg_i,
  input  logic [4:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re1_i,
  input  logic [4:0]        raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [4:0]        raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [31:0]       wcnt_o
);

  localparam int AW = 5;

  // x0 has no storage at all; it exists only as a constant in the read view.
  logic [DATA_W-1:0] r_mem [1:NREG-1];
  logic [DATA_W-1:0] w_entry [NREG];
  logic [31:0]       r_wcnt;
  logic              w_commit;

  // A write commits only outside reset, when enabled, and never to x0.
  assign w_commit = !rst && wreg_i && (waddr_i != '0);

  assign w_entry[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_entry
      // Per-entry storage: cleared by reset, loaded when the committed write targets it.
      always_ff @(posedge dclk) begin
        if (rst) begin
          r_mem[gi] <= '0;
        end else if (w_commit && (waddr_i == AW'(gi))) begin
          r_mem[gi] <= wdata_i;
        end
      end
      assign w_entry[gi] = r_mem[gi];
    end
  endgenerate

  // Gather both read ports into arrays so one generate loop builds them.
  logic              w_re    [2];
  logic [AW-1:0]     w_raddr [2];
  logic [DATA_W-1:0] w_rdata [2];

  assign w_re[0]    = re1_i;
  assign w_re[1]    = re2_i;
  assign w_raddr[0] = raddr1_i;
  assign w_raddr[1] = raddr2_i;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rport
      logic w_hit;
      // Forward the in-flight write when it targets the same non-zero index.
      assign w_hit = wreg_i && (waddr_i == w_raddr[gi]) && (w_raddr[gi] != '0);

      // Read mux: reset and disabled ports force zero, forwarding beats storage.
      always_comb begin
        w_rdata[gi] = '0;
        if (rst || !w_re[gi] || (w_raddr[gi] == '0)) begin
          w_rdata[gi] = '0;
        end else if (w_hit) begin
          w_rdata[gi] = wdata_i;
        end else begin
          w_rdata[gi] = w_entry[w_raddr[gi]];
        end
      end
    end
  endgenerate

  assign rdata1_o = w_rdata[0];
  assign rdata2_o = w_rdata[1];

  // Commit counter; natural 32-bit wrap, no overflow flag.
  always_ff @(posedge dclk) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (w_commit) begin
      r_wcnt <= r_wcnt + 32'd1;
    end
  end

  assign wcnt_o = r_wcnt;

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed scenarios followed by random traffic. A driver pushes
// the expected read data and write count for every cycle into a queue; a
// monitor on the falling edge pops and compares against the DUT.
module tb_regfile;

  logic        dclk;
  logic        rst;
  logic        wreg_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic        re1_i;
  logic [4:0]  raddr1_i;
  logic [31:0] rdata1_o;
  logic        re2_i;
  logic [4:0]  raddr2_i;
  logic [31:0] rdata2_o;
  logic [31:0] wcnt_o;

  regfile #(.DATA_W(32), .NREG(32)) dut (
    .dclk     (dclk),
    .rst      (rst),
    .wreg_i   (wreg_i),
    .waddr_i  (waddr_i),
    .wdata_i  (wdata_i),
    .re1_i    (re1_i),
    .raddr1_i (raddr1_i),
    .rdata1_o (rdata1_o),
    .re2_i    (re2_i),
    .raddr2_i (raddr2_i),
    .rdata2_o (rdata2_o),
    .wcnt_o   (wcnt_o)
  );

  initial dclk = 1'b0;
  always #5 dclk = ~dclk;

  typedef struct {
    int          id;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: architectural contents and commit count.
  logic [31:0] model_mem [32];
  logic [31:0] model_cnt;
  int          txn_id;

  int n_checks;
  int n_fail;

  function automatic logic [31:0] model_read(input logic r, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd,
                                             input logic re, input logic [4:0] ra);
    if (r || !re || ra == 5'd0) return 32'd0;
    if (we && wa == ra) return wd;
    return model_mem[ra];
  endfunction

  // Apply one cycle of stimulus, record expectation, then advance the model.
  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic e1, input logic [4:0] a1,
                       input logic e2, input logic [4:0] a2);
    exp_t e;
    @(posedge dclk);
    #1;
    rst = r; wreg_i = we; waddr_i = wa; wdata_i = wd;
    re1_i = e1; raddr1_i = a1; re2_i = e2; raddr2_i = a2;
    e.id  = txn_id;
    e.r1  = model_read(r, we, wa, wd, e1, a1);
    e.r2  = model_read(r, we, wa, wd, e2, a2);
    e.cnt = model_cnt;
    exp_q.push_back(e);
    txn_id++;
    if (r) begin
      for (int k = 0; k < 32; k++) model_mem[k] = 32'd0;
      model_cnt = 32'd0;
    end else if (we && wa != 5'd0) begin
      model_mem[wa] = wd;
      model_cnt = model_cnt + 32'd1;
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result.
  always @(negedge dclk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      $display("txn %0d: rst=%0b we=%0b wa=%0d wd=%08h re1=%0b a1=%0d re2=%0b a2=%0d -> r1=%08h r2=%08h cnt=%08h",
               e.id, rst, wreg_i, waddr_i, wdata_i, re1_i, raddr1_i, re2_i, raddr2_i,
               rdata1_o, rdata2_o, wcnt_o);
      n_checks++;
      if (rdata1_o !== e.r1) begin
        n_fail++;
        $display("FAIL rdata1 txn %0d: got %08h expected %08h", e.id, rdata1_o, e.r1);
      end
      n_checks++;
      if (rdata2_o !== e.r2) begin
        n_fail++;
        $display("FAIL rdata2 txn %0d: got %08h expected %08h", e.id, rdata2_o, e.r2);
      end
      n_checks++;
      if (wcnt_o !== e.cnt) begin
        n_fail++;
        $display("FAIL wcnt txn %0d: got %08h expected %08h", e.id, wcnt_o, e.cnt);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    txn_id   = 0;
    model_cnt = 32'd0;
    for (int k = 0; k < 32; k++) model_mem[k] = 32'hFFFF_FFFF;
    rst = 1'b1; wreg_i = 1'b0; waddr_i = 5'd0; wdata_i = 32'd0;
    re1_i = 1'b0; raddr1_i = 5'd0; re2_i = 1'b0; raddr2_i = 5'd0;

    // Reset with a write to x3 and enabled reads: reads zero, write discarded.
    drive(1, 0, 5'd0, 32'd0, 1, 5'd3, 1, 5'd3);
    drive(1, 1, 5'd3, 32'h55, 1, 5'd3, 1, 5'd3);
    drive(0, 0, 5'd0, 32'd0, 1, 5'd3, 0, 5'd0);
    // Write x5, read it back the next cycle.
    drive(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 0, 5'd0);
    drive(0, 0, 5'd0, 32'd0, 1, 5'd5, 0, 5'd0);
    // Write to x0 is ignored and not counted.
    drive(0, 1, 5'd0, 32'h1234_5678, 1, 5'd0, 1, 5'd0);
    drive(0, 0, 5'd0, 32'd0, 1, 5'd0, 1, 5'd0);
    // x7 = 1, then overwrite with both ports forwarding the new value.
    drive(0, 1, 5'd7, 32'h1, 0, 5'd0, 0, 5'd0);
    drive(0, 1, 5'd7, 32'hA5A5_A5A5, 1, 5'd7, 1, 5'd7);
    drive(0, 0, 5'd0, 32'd0, 1, 5'd7, 1, 5'd7);
    // Disabled port reads zero; enabled port sees stored x5.
    drive(0, 0, 5'd0, 32'd0, 0, 5'd5, 1, 5'd5);
    // Back-to-back writes to the same index: last wins, each counted.
    drive(0, 1, 5'd9, 32'h1111_1111, 1, 5'd9, 0, 5'd0);
    drive(0, 1, 5'd9, 32'h2222_2222, 1, 5'd9, 1, 5'd9);
    drive(0, 0, 5'd0, 32'd0, 1, 5'd9, 1, 5'd9);

    // Preload the commit counter to all-ones, then one write wraps it.
    @(negedge dclk);
    #1;
    force dut.r_wcnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_wcnt;
    model_cnt = 32'hFFFF_FFFF;
    drive(0, 1, 5'd1, 32'hCAFE_0001, 1, 5'd1, 0, 5'd0);
    drive(0, 0, 5'd0, 32'd0, 1, 5'd1, 1, 5'd5);

    // Mid-operation reset wipes contents; first write afterwards works normally.
    drive(1, 1, 5'd5, 32'h7777_7777, 1, 5'd5, 1, 5'd7);
    drive(0, 0, 5'd0, 32'd0, 1, 5'd5, 1, 5'd7);
    drive(0, 1, 5'd4, 32'h0BAD_F00D, 1, 5'd4, 0, 5'd4);
    drive(0, 0, 5'd0, 32'd0, 1, 5'd4, 1, 5'd4);

    // Random traffic; small address range makes forwarding hits frequent.
    for (int i = 0; i < 300; i++) begin
      logic        r, we, e1, e2;
      logic [4:0]  wa, a1, a2;
      logic [31:0] wd;
      r  = ($urandom_range(0, 39) == 0);
      we = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wd = $urandom;
      e1 = ($urandom_range(0, 4) != 0);
      e2 = ($urandom_range(0, 4) != 0);
      a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(r, we, wa, wd, e1, a1, e2, a2);
    end

    @(posedge dclk);
    @(negedge dclk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
